crc8_stream_tx: RTL and testbench

Transmit-side companion of the CRC8816 checker. Accepts a payload byte stream over a valid/ready handshake, computes the CRC-8 on the fly and appends it as one extra trailing byte. The stream it emits, fed to CRC8816, yields `o_match = 1`. Sits between a packet source and the serial/byte link that feeds the receiving checker.

---
 rtl/crc8_stream_tx.sv | 148 ++++++++++++++
 tb/tb_crc8_stream_tx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/crc8_stream_tx.sv
// rtl/crc8_stream_tx.sv - byte-stream CRC-8 generator that appends the CRC as a trailing byte (optional length limit: CRC8_TX_LEN_CHECK_EN)
module crc8_stream_tx #(
    parameter int MAX_BYTES = 4,
    parameter int CNT_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_valid,
    input  logic       i_last,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_valid,
    output logic       o_last,
    output logic [7:0] o_data,
    input  logic       i_ready,
    output logic [7:0] o_crc8,
    output logic       o_done,
    output logic       o_error
);

    localparam logic [7:0] CRC_INIT = 8'h0D;

    typedef enum logic {
        BODY,
        APPEND
    } state_t;

    state_t           state_q, state_d;
    logic             o_valid_q, o_valid_d;
    logic             o_last_q, o_last_d;
    logic [7:0]       o_data_q, o_data_d;
    logic [7:0]       crc_q, crc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             done_q, done_d;
    logic             out_free;
    logic             in_xfer;
    logic             error_q, error_d;

    // One payload byte folded into the CRC: xor in, then 8 MSB-first steps of poly 0x07
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    assign out_free = !o_valid_q || i_ready;
    assign in_xfer  = i_valid && o_ready;

    // Next-state, handshake and output-register load decisions
    always_comb begin
        state_d   = state_q;
        o_valid_d = o_valid_q;
        o_last_d  = o_last_q;
        o_data_d  = o_data_q;
        crc_d     = crc_q;
        count_d   = count_q;
        error_d   = error_q;
        o_ready   = 1'b0;
        done_d    = o_valid_q && i_ready && o_last_q;

        // A free output register empties unless something reloads it below
        if (out_free) begin
            o_valid_d = 1'b0;
        end

        unique case (state_q)
            BODY: begin
`ifdef CRC8_TX_LEN_CHECK_EN
                if (count_q == CNT_W'(MAX_BYTES)) begin
                    // Packet hit the length limit without i_last: close it here
                    state_d = APPEND;
                    error_d = 1'b1;
                end else begin
                    o_ready = out_free;
                end
`else
                o_ready = out_free;
`endif
                if (in_xfer) begin
                    o_valid_d = 1'b1;
                    o_last_d  = 1'b0;
                    o_data_d  = i_data;
                    crc_d     = crc8_byte(crc_q, i_data);
                    count_d   = count_q + CNT_W'(1);
                    if (i_last) begin
                        state_d = APPEND;
                    end
                end
            end
            APPEND: begin
                if (out_free) begin
                    o_valid_d = 1'b1;
                    o_last_d  = 1'b1;
                    o_data_d  = crc_q;
                    crc_d     = CRC_INIT;
                    count_d   = '0;
                    state_d   = BODY;
                end
            end
            default: state_d = BODY;
        endcase
    end

    // State, output register, CRC and counter storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= BODY;
            o_valid_q <= 1'b0;
            o_last_q  <= 1'b0;
            o_data_q  <= 8'h00;
            crc_q     <= CRC_INIT;
            count_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            o_valid_q <= o_valid_d;
            o_last_q  <= o_last_d;
            o_data_q  <= o_data_d;
            crc_q     <= crc_d;
            count_q   <= count_d;
            done_q    <= done_d;
        end
    end

`ifdef CRC8_TX_LEN_CHECK_EN
    // Sticky length-overflow flag, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end
`else
    assign error_q = 1'b0;
`endif

    assign o_valid = o_valid_q;
    assign o_last  = o_last_q;
    assign o_data  = o_data_q;
    assign o_crc8  = crc_q;
    assign o_done  = done_q;
    assign o_error = error_q;

endmodule

// File: tb/tb_crc8_stream_tx.sv
// tb/tb_crc8_stream_tx.sv - scoreboard testbench for crc8_stream_tx
module tb_crc8_stream_tx;

    localparam int MAX_BYTES = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_valid;
    logic       i_last;
    logic [7:0] i_data;
    logic       o_ready;
    logic       o_valid;
    logic       o_last;
    logic [7:0] o_data;
    logic       i_ready;
    logic [7:0] o_crc8;
    logic       o_done;
    logic       o_error;

    crc8_stream_tx #(.MAX_BYTES(MAX_BYTES)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_valid (i_valid),
        .i_last  (i_last),
        .i_data  (i_data),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_last  (o_last),
        .o_data  (o_data),
        .i_ready (i_ready),
        .o_crc8  (o_crc8),
        .o_done  (o_done),
        .o_error (o_error)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [8:0]  sb_q[$];
    logic [7:0]  mcrc = 8'h0D;
    int          mcnt = 0;
    logic        exp_err = 1'b0;
    logic        stall_mode = 1'b0;
    logic [3:0]  ready_pat = 4'b1001;
    int          cyc = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] crc8_ref(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) c = {c[6:0], 1'b0} ^ 8'h07;
            else      c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

    // Downstream ready: always 1, or the 1,0,0,1 stall pattern
    always @(posedge clk) begin
        #1;
        cyc++;
        i_ready = stall_mode ? ready_pat[cyc % 4] : 1'b1;
    end

    // Output monitor: scoreboard pop, stall stability, done pulse, receiver residue
    logic       done_exp = 1'b0;
    logic       hold_v = 1'b0;
    logic [9:0] hold_val = '0;
    logic [7:0] rx_crc = 8'h0D;
    always @(negedge clk) begin
        if (reset) begin
            done_exp = 1'b0;
            hold_v   = 1'b0;
            rx_crc   = 8'h0D;
        end else begin
            chk("o_done", {15'd0, o_done}, {15'd0, done_exp});
            done_exp = 1'b0;
            if (hold_v) chk("stall_hold", {6'd0, o_valid, o_last, o_data}, {6'd0, hold_val});
            hold_v   = o_valid && !i_ready;
            hold_val = {o_valid, o_last, o_data};
            if (o_valid && i_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_out", {7'd0, o_last, o_data}, 16'hFFFF);
                end else begin
                    logic [8:0] e;
                    e = sb_q.pop_front();
                    chk("out_byte", {7'd0, o_last, o_data}, {7'd0, e});
                    rx_crc = crc8_ref(rx_crc, o_data);
                    if (o_last) begin
                        chk("rx_residue", {8'd0, rx_crc}, 16'h0000);
                        rx_crc   = 8'h0D;
                        done_exp = 1'b1;
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic last);
        int   waited;
        logic acc;
        waited  = 0;
        i_valid = 1'b1;
        i_data  = d;
        i_last  = last;
        forever begin
            @(negedge clk);
            acc = o_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            waited++;
            if (waited > 50) begin
                chk("accept_timeout", 16'(waited), 16'd0);
                i_valid = 1'b0;
                return;
            end
        end
        mcrc = crc8_ref(mcrc, d);
        mcnt++;
        sb_q.push_back({1'b0, d});
        chk("run_crc", {8'd0, o_crc8}, {8'd0, mcrc});
        if (last) begin
            sb_q.push_back({1'b1, mcrc});
            mcrc = 8'h0D;
            mcnt = 0;
        end
`ifdef CRC8_TX_LEN_CHECK_EN
        else if (mcnt == MAX_BYTES) begin
            sb_q.push_back({1'b1, mcrc});
            mcrc    = 8'h0D;
            mcnt    = 0;
            exp_err = 1'b1;
        end
`endif
    endtask

    task automatic idle_drain();
        int n;
        i_valid = 1'b0;
        i_last  = 1'b0;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("drain", 16'(sb_q.size()), 16'd0);
        chk("crc_idle", {8'd0, o_crc8}, 16'h000D);
    endtask

    initial begin
        logic [7:0] pkt4[4];
        logic [7:0] pkt_b[4];
        reset   = 1'b1;
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_data  = 8'h00;
        i_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_crc",   {8'd0, o_crc8}, 16'h000D);
        chk("rst_valid", {15'd0, o_valid}, 16'd0);
        chk("rst_last",  {15'd0, o_last}, 16'd0);
        chk("rst_data",  {8'd0, o_data}, 16'd0);
        chk("rst_ready", {15'd0, o_ready}, 16'd1);
        chk("rst_done",  {15'd0, o_done}, 16'd0);
        chk("rst_error", {15'd0, o_error}, 16'd0);

        // Single 0x00 byte: CRC byte 0x23
        chk("ref_crc_00", {8'd0, crc8_ref(8'h0D, 8'h00)}, 16'h0023);
        send_byte(8'h00, 1'b1);
        idle_drain();

        // Single 0x0D byte: CRC byte 0x00
        chk("ref_crc_0d", {8'd0, crc8_ref(8'h0D, 8'h0D)}, 16'h0000);
        send_byte(8'h0D, 1'b1);
        idle_drain();

        // Four bytes with downstream stalls
        stall_mode = 1'b1;
        pkt4 = '{8'hA5, 8'h3C, 8'hFF, 8'h81};
        for (int i = 0; i < 4; i++) send_byte(pkt4[i], i == 3);
        idle_drain();
        stall_mode = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back packets, gapless output
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b1);
        send_byte(8'h56, 1'b1);
        idle_drain();

        // Reset after two of four payload bytes
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        i_valid = 1'b0;
        reset   = 1'b1;
        #1;
        chk("midrst_valid", {15'd0, o_valid}, 16'd0);
        chk("midrst_crc",   {8'd0, o_crc8}, 16'h000D);
        sb_q.delete();
        mcrc = 8'h0D;
        mcnt = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_no_crc", {15'd0, o_valid}, 16'd0);
        pkt_b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        for (int i = 0; i < 4; i++) send_byte(pkt_b[i], i == 3);
        idle_drain();

        // Five bytes, i_last only on the fifth
        for (int i = 1; i <= 5; i++) send_byte(8'(i), i == 5);
        idle_drain();
        chk("error_flag", {15'd0, o_error}, {15'd0, exp_err});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
